// File: rtl/tpx3_datain_rx.sv
// Timepix3 DataIn/EnableIn command-link receiver: recovers framed bytes behind a sync byte
// and queues them with SOF/EOF markers in a first-word fall-through FIFO, counting link errors.
module tpx3_datain_rx #(
  parameter logic [7:0] SYNC_BYTE  = 8'hAA,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic        i_clk40,
  input  logic        i_rst_n,
  input  logic        i_en_in,
  input  logic        i_data_in,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_sof,
  output logic        o_rx_eof,
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  input  logic        i_clr_cnt,
  output logic [15:0] o_frame_cnt,
  output logic [7:0]  o_sync_err_cnt,
  output logic [7:0]  o_trunc_err_cnt,
  output logic [7:0]  o_ovf_cnt,
  output logic        o_ovf_flag
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = 1;
  localparam logic [AW-1:0] C_PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_DATA, S_DROP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    w_byte;
  logic          r_armed;
  logic          r_first;
  logic          r_held_vld;
  logic          r_held_sof;
  logic [7:0]    r_held;
  logic          r_wr_en;
  logic [9:0]    r_wr_word;

  logic          w_shift;
  logic          w_byte_done;
  logic          w_sync_ok;
  logic          w_sync_err;
  logic          w_pay_done;
  logic          w_frame_end;
  logic          w_trunc;
  logic          w_push;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          w_pop;
  logic          w_full;
  logic          w_fifo_we;
  logic          w_drop;
  logic [9:0]    w_head;

  logic [15:0]   r_frame_cnt;
  logic [7:0]    r_sync_err_cnt;
  logic [7:0]    r_trunc_err_cnt;
  logic [7:0]    r_ovf_cnt;
  logic          r_ovf_flag;

  assign w_byte = {r_shift[6:0], i_data_in};

  always_ff @(posedge i_clk40 or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (i_en_in && r_armed) w_state_next = S_HUNT;
      S_HUNT: begin
        if (!i_en_in)             w_state_next = S_IDLE;
        else if (r_bit_cnt == 3'd7) w_state_next = (w_byte == SYNC_BYTE) ? S_DATA : S_DROP;
      end
      S_DATA: if (!i_en_in) w_state_next = S_IDLE;
      S_DROP: if (!i_en_in) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // IDLE shifts too: the cycle EN_IN rises already carries bit 7 of the sync byte.
  always_comb begin
    w_shift     = i_en_in && (((r_state == S_IDLE) && r_armed) ||
                              (r_state == S_HUNT) || (r_state == S_DATA));
    w_byte_done = w_shift && (r_bit_cnt == 3'd7);
    w_sync_ok   = (r_state == S_HUNT) && w_byte_done && (w_byte == SYNC_BYTE);
    w_sync_err  = (r_state == S_HUNT) && w_byte_done && (w_byte != SYNC_BYTE);
    w_pay_done  = (r_state == S_DATA) && w_byte_done;
    w_frame_end = (r_state == S_DATA) && !i_en_in;
    w_trunc     = ((r_state == S_HUNT) || (r_state == S_DATA)) && !i_en_in && (r_bit_cnt != 3'd0);
    w_push      = (w_pay_done || w_frame_end) && r_held_vld;
  end

  // r_armed stays low after reset until EN_IN is seen low, so a frame cut by reset never resumes.
  always_ff @(posedge i_clk40 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_first    <= 1'b0;
      r_held_vld <= 1'b0;
      r_held_sof <= 1'b0;
      r_held     <= 8'd0;
      r_wr_en    <= 1'b0;
      r_wr_word  <= 10'd0;
    end else begin
      if (!i_en_in) r_armed <= 1'b1;
      if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= w_byte;
      end else if (!i_en_in) begin
        r_bit_cnt <= 3'd0;
      end
      if (w_sync_ok)       r_first <= 1'b1;
      else if (w_pay_done) r_first <= 1'b0;
      if (w_pay_done) begin
        r_held_vld <= 1'b1;
        r_held_sof <= r_first;
        r_held     <= w_byte;
      end else if (w_frame_end) begin
        r_held_vld <= 1'b0;
      end
      r_wr_en   <= w_push;
      r_wr_word <= {r_held_sof, w_frame_end, r_held};
    end
  end

  assign w_pop     = (r_count != '0) && i_rx_ready;
  assign w_full    = (r_count == C_DEPTH);
  assign w_fifo_we = r_wr_en && (!w_full || w_pop);
  assign w_drop    = r_wr_en && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_fifo_we, w_pop})
      2'b10:   w_count_next = r_count + C_CNT_ONE;
      2'b01:   w_count_next = r_count - C_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk40) begin
    if (w_fifo_we) r_mem[r_wr_ptr] <= r_wr_word;
  end

  always_ff @(posedge i_clk40 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fifo_we) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      r_count <= w_count_next;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign o_rx_valid = (r_count != '0);
  assign o_rx_data  = o_rx_valid ? w_head[7:0] : 8'd0;
  assign o_rx_eof   = o_rx_valid & w_head[8];
  assign o_rx_sof   = o_rx_valid & w_head[9];

  // A frame whose EOF byte was dropped still counts: the count tracks the link, not the consumer.
  always_ff @(posedge i_clk40 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt     <= 16'd0;
      r_sync_err_cnt  <= 8'd0;
      r_trunc_err_cnt <= 8'd0;
      r_ovf_cnt       <= 8'd0;
      r_ovf_flag      <= 1'b0;
    end else if (i_clr_cnt) begin
      r_frame_cnt     <= 16'd0;
      r_sync_err_cnt  <= 8'd0;
      r_trunc_err_cnt <= 8'd0;
      r_ovf_cnt       <= 8'd0;
      r_ovf_flag      <= 1'b0;
    end else begin
      if (w_frame_end && r_held_vld)                r_frame_cnt     <= r_frame_cnt + 16'd1;
      if (w_sync_err && (r_sync_err_cnt != 8'hFF))  r_sync_err_cnt  <= r_sync_err_cnt + 8'd1;
      if (w_trunc && (r_trunc_err_cnt != 8'hFF))    r_trunc_err_cnt <= r_trunc_err_cnt + 8'd1;
      if (w_drop && (r_ovf_cnt != 8'hFF))           r_ovf_cnt       <= r_ovf_cnt + 8'd1;
      if (w_drop)                                   r_ovf_flag      <= 1'b1;
    end
  end

  assign o_frame_cnt     = r_frame_cnt;
  assign o_sync_err_cnt  = r_sync_err_cnt;
  assign o_trunc_err_cnt = r_trunc_err_cnt;
  assign o_ovf_cnt       = r_ovf_cnt;
  assign o_ovf_flag      = r_ovf_flag;

endmodule

// File: tb/tb_tpx3_datain_rx.sv
// Bench for tpx3_datain_rx: directed and random frames against a byte-level frame model.
module tb_tpx3_datain_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in;
  logic        data_in;
  logic [7:0]  rx_data;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_valid;
  logic        rx_ready;
  logic        clr_cnt;
  logic [15:0] frame_cnt;
  logic [7:0]  sync_err_cnt;
  logic [7:0]  trunc_err_cnt;
  logic [7:0]  ovf_cnt;
  logic        ovf_flag;

  always #5 clk = ~clk;

  tpx3_datain_rx dut (
    .i_clk40        (clk),
    .i_rst_n        (rst_n),
    .i_en_in        (en_in),
    .i_data_in      (data_in),
    .o_rx_data      (rx_data),
    .o_rx_sof       (rx_sof),
    .o_rx_eof       (rx_eof),
    .o_rx_valid     (rx_valid),
    .i_rx_ready     (rx_ready),
    .i_clr_cnt      (clr_cnt),
    .o_frame_cnt    (frame_cnt),
    .o_sync_err_cnt (sync_err_cnt),
    .o_trunc_err_cnt(trunc_err_cnt),
    .o_ovf_cnt      (ovf_cnt),
    .o_ovf_flag     (ovf_flag)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  fb[$];
  logic [15:0] exp_frame;
  logic [7:0]  exp_sync;
  logic [7:0]  exp_trunc;
  logic [7:0]  exp_ovf;
  logic        exp_flag;
  bit          hold_mode  = 0;
  bit          rand_ready = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"}, 32'(frame_cnt),     32'(exp_frame));
    check({tag, "_sync_err"},  32'(sync_err_cnt),  32'(exp_sync));
    check({tag, "_trunc_err"}, 32'(trunc_err_cnt), 32'(exp_trunc));
    check({tag, "_ovf_cnt"},   32'(ovf_cnt),       32'(exp_ovf));
    check({tag, "_ovf_flag"},  32'(ovf_flag),      32'(exp_flag));
  endtask

  task automatic model_clear();
    exp_frame = 16'd0; exp_sync = 8'd0; exp_trunc = 8'd0; exp_ovf = 8'd0; exp_flag = 1'b0;
  endtask

  // Frame rules: byte 0 must be the sync byte; the rest is payload; leftover bits are a truncation.
  task automatic model_frame(input int nx, input bit clr);
    int nb = fb.size();
    if (nb == 0) begin
      if (nx != 0) exp_trunc = sat_inc(exp_trunc);
    end else if (fb[0] != 8'hAA) begin
      exp_sync = sat_inc(exp_sync);
    end else begin
      for (int i = 1; i < nb; i++) begin
        logic s = (i == 1);
        logic e = (i == nb - 1);
        if (hold_mode && exp_q.size() >= 16) begin
          exp_ovf  = sat_inc(exp_ovf);
          exp_flag = 1'b1;
        end else begin
          exp_q.push_back({s, e, fb[i]});
        end
      end
      if (nb > 1) exp_frame = exp_frame + 16'd1;
      if (nx != 0) exp_trunc = sat_inc(exp_trunc);
    end
    if (clr) model_clear();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic d);
    en_in   = e;
    data_in = d;
    if (rand_ready) rx_ready = ($urandom_range(3) != 0);
    tick();
  endtask

  task automatic send_bits(input int nx);
    logic [7:0] bv;
    for (int i = 0; i < fb.size(); i++) begin
      bv = fb[i];
      for (int k = 7; k >= 0; k--) drive(1'b1, bv[k]);
    end
    for (int k = 0; k < nx; k++) drive(1'b1, 1'($urandom_range(1)));
  endtask

  task automatic send_frame(input int nx, input bit clr);
    model_frame(nx, clr);
    send_bits(nx);
    clr_cnt = clr;
    drive(1'b0, 1'b0);
    clr_cnt = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 400;
    rand_ready = 0;
    rx_ready   = 1'b1;
    en_in      = 1'b0;
    while (budget > 0 && (rx_valid || exp_q.size() != 0)) begin
      tick();
      budget--;
    end
    repeat (3) tick();
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid_idle"}, 32'(rx_valid), 32'd0);
  endtask

  // Every accepted head is compared with the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) check("rx_extra_byte", 32'(rx_valid), 32'd0);
      else check("rx_word", 32'({rx_sof, rx_eof, rx_data}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0; en_in = 1'b0; data_in = 1'b0; rx_ready = 1'b1; clr_cnt = 1'b0;
    model_clear();
    repeat (3) tick();
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_head",  32'({rx_sof, rx_eof, rx_data}), 32'd0);
    check_counters("rst");
    rst_n = 1'b1;
    repeat (2) tick();

    // AA 12 34 -> 12 SOF, 34 EOF
    fb.delete(); fb.push_back(8'hAA); fb.push_back(8'h12); fb.push_back(8'h34);
    send_frame(0, 0);
    drain("t1");
    check_counters("t1");

    // single-byte frame, with latency from EN_IN fall
    fb.delete(); fb.push_back(8'hAA); fb.push_back(8'h5C);
    model_frame(0, 0);
    send_bits(0);
    en_in = 1'b0; data_in = 1'b0;
    tick();
    check("lat_fall_plus1", 32'(rx_valid), 32'd0);
    tick();
    check("lat_fall_plus2", 32'(rx_valid), 32'd1);
    check("lat_head", 32'({rx_sof, rx_eof, rx_data}), 32'h35C);
    drain("t2a");
    fb.delete(); fb.push_back(8'hAA);
    send_frame(0, 0);
    drain("t2b");
    check_counters("t2");

    // bad sync, then good frame
    fb.delete(); fb.push_back(8'h55); fb.push_back(8'h12);
    send_frame(0, 0);
    fb.delete(); fb.push_back(8'hAA); fb.push_back(8'h01);
    send_frame(0, 0);
    drain("t3");
    check_counters("t3");

    // trailing partial byte; then a frame that dies in HUNT
    fb.delete(); fb.push_back(8'hAA); fb.push_back(8'h12);
    send_frame(3, 0);
    fb.delete();
    send_frame(5, 0);
    drain("t4");
    check_counters("t4");

    // clear on the same cycle as the frame-end increment
    fb.delete(); fb.push_back(8'hAA); fb.push_back(8'h33); fb.push_back(8'h44);
    send_frame(0, 1);
    drain("clr_edge");
    check_counters("clr_edge");

    // overflow: consumer stalled, 20 payload bytes into a 16-deep FIFO
    rx_ready = 1'b0; hold_mode = 1;
    fb.delete(); fb.push_back(8'hAA);
    for (int i = 0; i < 20; i++) fb.push_back(8'($urandom_range(255)));
    send_frame(0, 0);
    repeat (4) tick();
    check("t5_valid_full", 32'(rx_valid), 32'd1);
    check_counters("t5");
    hold_mode = 0;
    drain("t5");
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    model_clear();
    tick();
    check_counters("t5_clr");

    // reset mid-frame, released while EN_IN stays high
    fb.delete(); fb.push_back(8'hAA); fb.push_back(8'h12); fb.push_back(8'hAA); fb.push_back(8'h77);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] bv = fb[i / 8];
      if (i == 13) begin
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_clear();
        check("t6_rst_valid", 32'(rx_valid), 32'd0);
      end
      if (i == 16) rst_n = 1'b1;
      drive(1'b1, bv[7 - (i % 8)]);
    end
    check("t6_no_output", 32'(rx_valid), 32'd0);
    drive(1'b0, 1'b0);
    repeat (3) tick();
    check_counters("t6_after_rst");
    fb.delete(); fb.push_back(8'hAA); fb.push_back(8'h01);
    send_frame(0, 0);
    drain("t6");
    check_counters("t6");

    // random frames with a jittery consumer
    for (int f = 0; f < 40; f++) begin
      int nb = $urandom_range(6);
      int nx = ($urandom_range(3) == 0) ? $urandom_range(7, 1) : 0;
      rand_ready = 1;
      fb.delete();
      if (nb == 0 && nx == 0) nx = $urandom_range(7, 1);
      for (int i = 0; i < nb; i++) begin
        logic [7:0] r = 8'($urandom_range(255));
        if (i == 0) begin
          if ($urandom_range(5) != 0) r = 8'hAA;
          else if (r == 8'hAA) r = 8'h00;
        end
        fb.push_back(r);
      end
      send_frame(nx, 0);
      repeat ($urandom_range(2)) drive(1'b0, 1'b0);
    end
    drain("rand");
    check_counters("rand");

    // sync error counter saturation
    fb.delete(); fb.push_back(8'h00);
    for (int f = 0; f < 260; f++) send_frame(0, 0);
    repeat (2) tick();
    check_counters("sat");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
